instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage for the MIPS-subset core. It owns the program counter and fetches each instruction from instruction memory over a ready handshake. It holds the fetched word stable for the decoder and datapath until the datapath retires it. On retire it computes the next PC from the decoder's `branch` code, the ALU `zero` flag and the held instruction's immediate or jump index.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Must be word-aligned.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `imem_req`, output, 1: fetch request to instruction memory.
- `imem_addr`, output, 32: fetch address. Always equals `pc`.
- `imem_ready`, input, 1: memory returns `imem_rdata` this cycle. Sampled only while `imem_req` is high.
- `imem_rdata`, input, 32: instruction word.
- `instr`, output, 32: held instruction. Feeds the control unit (opcode = [31:26], funct = [5:0]).
- `instr_valid`, output, 1: `instr` is valid and awaiting retire.
- `pc`, output, 32: address of the held or in-flight instruction.
- `pc_plus4`, output, 32: `pc` + 4. This is the link value for jal.
- `retire`, input, 1: datapath commits the held instruction this cycle.
- `branch`, input, 2: branch code from the control unit. 00 none, 01 bne, 10 beq, 11 jump (j/jal).
- `zero`, input, 1: ALU zero flag for the held instruction.
- `instret`, output, 32: count of retired instructions.

## Operation

- Three-state FSM: IDLE, FETCH, EXEC.
- IDLE: entered only by reset.
  - `imem_req` = 0.
  - Moves unconditionally to FETCH on the next edge.
- FETCH:
  - `imem_req` = 1, `imem_addr` = `pc`.
  - When `imem_ready` = 1: capture `imem_rdata` into `instr` and go to EXEC.
  - Otherwise stay in FETCH, with address and request held stable.
- EXEC:
  - `instr_valid` = 1 and `imem_req` = 0.
  - `instr` and `pc` are held constant.
  - When `retire` = 1: load `pc` with the next PC, increment `instret`, go to FETCH.
- Next PC (combinational, from held `instr`):
  - Branch target = `pc_plus4` + (sign-extend(`instr[15:0]`) << 2).
  - Jump target = {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}.
  - Taken when `branch` = 10 and `zero` = 1, or `branch` = 01 and `zero` = 0 → branch target.
  - `branch` = 11 → jump target, regardless of `zero`.
  - Otherwise → `pc_plus4`.
- Arithmetic is 32-bit modulo 2^32: PC 32'hFFFF_FFFC + 4 = 0. `instret` wraps from 32'hFFFF_FFFF to 0.
- `retire` outside EXEC is ignored. `branch` and `zero` are ignored outside a retire cycle.
- `imem_ready` outside FETCH is ignored. Data is never captured twice.

## Timing

- Reset values: `pc` = `RESET_PC`, `instr` = 0, `instr_valid` = 0, `imem_req` = 0, `instret` = 0, state = IDLE.
- Reset asserted mid-FETCH or mid-EXEC aborts immediately. The outstanding request is dropped, with no capture.
- First `imem_req` is on the second edge after `rst_n` rises (IDLE consumes one cycle).
- FETCH to EXEC takes 1 cycle after `imem_ready` is sampled high. `instr_valid` rises on that edge.
- Minimum two cycles per instruction: one FETCH cycle with immediate ready, plus one EXEC cycle with immediate retire.
- New `pc` is visible the cycle after retire, together with `imem_req` = 1.
- `pc_plus4` is combinational from `pc`. All other outputs are registered or decoded from state only. There is no combinational path from `imem_ready` or `retire` to any output.

## Structure

- Shared package holds:
  - branch code constants `BR_NONE` = 2'b00, `BR_BNE` = 2'b01, `BR_BEQ` = 2'b10, `BR_JUMP` = 2'b11;
  - FSM state encodings `ST_IDLE`, `ST_FETCH`, `ST_EXEC`;
  - the default reset PC.
- One combinational sub-module, `next_pc_logic`:
  - inputs: `pc_plus4`, `instr`, `branch`, `zero`;
  - output: next PC.
  - The control unit and a future jr extension can reuse this encoding.

## Test plan

- Reset then `imem_ready` tied 1, `rdata` = 32'h2008_0005, `retire` = 1, `branch` = 00 → `instr_valid` high in cycle 3, then `pc` = 4, `instret` = 1.
- Held instruction is beq with imm = 16'hFFFE at pc = 32'h100:
  - `branch` = 10, `zero` = 1, retire → next `pc` = 32'hFC.
  - Same with `zero` = 0 → `pc` = 32'h104.
- Held instruction is j with index 26'h000_0040 at pc = 32'h1000_0000, `branch` = 11 → `pc` = 32'h1000_0100 whether `zero` is 0 or 1.
- `imem_ready` held low for 5 cycles:
  - `imem_req` and `imem_addr` stay constant;
  - `instr_valid` stays 0;
  - a `retire` pulse during this window changes nothing.
- `retire` held low 4 cycles in EXEC → `instr` and `pc` stay stable, `instret` unchanged. Single retire → `instret` +1 exactly.
- `rst_n` pulsed low mid-FETCH with `imem_ready` = 1 → `instr` = 0, `pc` = `RESET_PC`, `instret` = 0 immediately, with no capture.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: branch codes, fetch FSM states and reset PC shared by the fetch stage
package instr_fetch_pkg;
   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_BNE  = 2'b01;
   localparam logic [1:0] BR_BEQ  = 2'b10;
   localparam logic [1:0] BR_JUMP = 2'b11;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC} state_t;
endpackage

// File: rtl/instr_fetch_next_pc_logic.sv
// next_pc_logic: selects fall-through, branch or jump target for the held instruction
module next_pc_logic
   import instr_fetch_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [31:0] instr,
   input  logic [1:0]  branch,
   input  logic        zero,
   output logic [31:0] next_pc
);
   logic [31:0] br_target;
   logic [31:0] jump_target;
   logic        taken;
   assign br_target   = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
   assign jump_target = {pc_plus4[31:28], instr[25:0], 2'b00};
   assign taken       = (branch == BR_BEQ && zero) || (branch == BR_BNE && !zero);
   assign next_pc     = branch == BR_JUMP ? jump_target : taken ? br_target : pc_plus4;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, fetches over a ready handshake and holds the word until retire
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        retire,
   input  logic [1:0]  branch,
   input  logic        zero,
   output logic [31:0] instret
);
   state_t      state;
   logic [31:0] next_pc;
   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;
   next_pc_logic u_next_pc (
      .pc_plus4 (pc_plus4),
      .instr    (instr),
      .branch   (branch),
      .zero     (zero),
      .next_pc  (next_pc)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         instr       <= '0;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
         instret     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state    <= ST_FETCH;
               imem_req <= 1'b1;
            end
            ST_FETCH: if (imem_ready) begin
               instr       <= imem_rdata;
               state       <= ST_EXEC;
               imem_req    <= 1'b0;
               instr_valid <= 1'b1;
            end
            ST_EXEC: if (retire) begin
               pc          <= next_pc;
               instret     <= instret + 32'd1;
               state       <= ST_FETCH;
               imem_req    <= 1'b1;
               instr_valid <= 1'b0;
            end
            default: begin
               state       <= ST_IDLE;
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed fetch/branch/stall/reset sequence with a PC and instruction scoreboard
module tb_instr_fetch;
   import instr_fetch_pkg::*;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        retire = 1'b0;
   logic [1:0]  branch = BR_NONE;
   logic        zero = 1'b0;
   logic        imem_req, instr_valid;
   logic [31:0] imem_addr, instr, pc, pc_plus4, instret;
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] q_pc[$];
   logic [31:0] q_instr[$];
   logic [31:0] m_pc, m_instret, m_instr;

   instr_fetch dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .instr      (instr),
      .instr_valid(instr_valid),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .retire     (retire),
      .branch     (branch),
      .zero       (zero),
      .instret    (instret)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] w);
      chk("fetch_req", {31'd0, imem_req}, 32'd1);
      chk("fetch_addr", imem_addr, m_pc);
      chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
      imem_ready = 1'b1;
      imem_rdata = w;
      q_instr.push_back(w);
      step();
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      m_instr = q_instr.pop_front();
      chk("cap_valid", {31'd0, instr_valid}, 32'd1);
      chk("cap_instr", instr, m_instr);
      chk("cap_pc", pc, m_pc);
      chk("cap_req", {31'd0, imem_req}, 32'd0);
   endtask

   task automatic ret(input logic [1:0] br, input logic z, input logic [31:0] npc);
      branch = br;
      zero = z;
      retire = 1'b1;
      q_pc.push_back(npc);
      m_instret = m_instret + 32'd1;
      step();
      retire = 1'b0;
      branch = BR_NONE;
      zero = 1'b0;
      m_pc = q_pc.pop_front();
      chk("ret_pc", pc, m_pc);
      chk("ret_pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("ret_instret", instret, m_instret);
      chk("ret_req", {31'd0, imem_req}, 32'd1);
      chk("ret_valid", {31'd0, instr_valid}, 32'd0);
   endtask

   initial begin
      step();
      step();
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_instret", instret, 32'h0);
      rst_n = 1'b1;
      m_pc = 32'h0;
      m_instret = 32'h0;
      imem_ready = 1'b1;
      imem_rdata = 32'h2008_0005;
      retire = 1'b1;
      branch = BR_NONE;
      step();
      chk("c1_req", {31'd0, imem_req}, 32'd1);
      chk("c1_valid", {31'd0, instr_valid}, 32'd0);
      step();
      chk("c2_valid", {31'd0, instr_valid}, 32'd1);
      chk("c2_instr", instr, 32'h2008_0005);
      chk("c2_pc", pc, 32'h0);
      step();
      imem_ready = 1'b0;
      retire = 1'b0;
      chk("c3_pc", pc, 32'h4);
      chk("c3_instret", instret, 32'h1);
      chk("c3_valid", {31'd0, instr_valid}, 32'd0);
      m_pc = 32'h4;
      m_instret = 32'h1;
      fetch(32'h0800_0040);
      ret(BR_JUMP, 1'b0, 32'h0000_0100);
      fetch(32'h1000_FFFE);
      ret(BR_BEQ, 1'b1, 32'h0000_00FC);
      fetch(32'h2008_0005);
      ret(BR_NONE, 1'b1, 32'h0000_0100);
      fetch(32'h1000_FFFE);
      ret(BR_BEQ, 1'b0, 32'h0000_0104);
      fetch(32'h0BFF_FFFF);
      ret(BR_JUMP, 1'b1, 32'h0FFF_FFFC);
      fetch(32'h0000_0000);
      ret(BR_NONE, 1'b0, 32'h1000_0000);
      fetch(32'h0800_0040);
      ret(BR_JUMP, 1'b0, 32'h1000_0100);
      fetch(32'h1400_FFBF);
      ret(BR_BNE, 1'b0, 32'h1000_0000);
      fetch(32'h0800_0040);
      ret(BR_JUMP, 1'b1, 32'h1000_0100);
      fetch(32'h1400_FFBF);
      ret(BR_BNE, 1'b1, 32'h1000_0104);
      retire = 1'b1;
      branch = BR_JUMP;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_req", {31'd0, imem_req}, 32'd1);
         chk("stall_addr", imem_addr, m_pc);
         chk("stall_valid", {31'd0, instr_valid}, 32'd0);
         chk("stall_instret", instret, m_instret);
      end
      retire = 1'b0;
      branch = BR_NONE;
      fetch(32'h2009_0007);
      imem_ready = 1'b1;
      imem_rdata = 32'h5555_AAAA;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("hold_instr", instr, 32'h2009_0007);
         chk("hold_pc", pc, m_pc);
         chk("hold_instret", instret, m_instret);
         chk("hold_valid", {31'd0, instr_valid}, 32'd1);
         chk("hold_req", {31'd0, imem_req}, 32'd0);
      end
      imem_ready = 1'b0;
      ret(BR_NONE, 1'b0, 32'h1000_0108);
      imem_ready = 1'b1;
      imem_rdata = 32'hCAFE_F00D;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_pc", pc, 32'h0);
      chk("arst_instr", instr, 32'h0);
      chk("arst_instret", instret, 32'h0);
      chk("arst_req", {31'd0, imem_req}, 32'd0);
      chk("arst_valid", {31'd0, instr_valid}, 32'd0);
      step();
      chk("arst_nocap", instr, 32'h0);
      rst_n = 1'b1;
      imem_ready = 1'b0;
      m_pc = 32'h0;
      m_instret = 32'h0;
      chk("idle_req", {31'd0, imem_req}, 32'd0);
      step();
      fetch(32'h1234_5678);
      ret(BR_NONE, 1'b0, 32'h4);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
